// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM-stage load/store port: configurable wait
// states, combinational busy, registered done/err/rdata, alignment checking.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [2:0]  func3,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   addr_q, wdata_q;
  logic [2:0]    func3_q;
  logic          store_q;
  logic          done_q, err_q;
  logic [31:0]   rdata_q;

  logic [31:0]   mem [DEPTH_WORDS];

  logic          req;
  logic          accept, do_access, err_d;
  logic [31:0]   rdata_d;

  // Access operands: live inputs on the accept edge, latched copies afterwards
  logic [31:0]   a_c, wd_c;
  logic [2:0]    f3_c;
  logic          st_c;

  assign req  = memread | memwrite;
  assign a_c  = (state_q == IDLE) ? addr     : addr_q;
  assign wd_c = (state_q == IDLE) ? wdata    : wdata_q;
  assign f3_c = (state_q == IDLE) ? func3    : func3_q;
  assign st_c = (state_q == IDLE) ? memwrite : store_q;

  // Upper address bits alias onto the array
  logic unused_addr_bits;
  assign unused_addr_bits = ^a_c[31:AW+2];

  logic          size_ok, align_ok, legal;

  // Legal func3 per op, and natural alignment for halfword/word
  always_comb begin
    size_ok  = 1'b0;
    align_ok = 1'b1;
    case (f3_c)
      3'b000, 3'b001, 3'b010: size_ok = 1'b1;
      3'b100, 3'b101:         size_ok = ~st_c;
      default:                size_ok = 1'b0;
    endcase
    if (f3_c[1:0] == 2'b01) begin
      align_ok = (a_c[0] == 1'b0);
    end else if (f3_c[1:0] == 2'b10) begin
      align_ok = (a_c[1:0] == 2'b00);
    end
    legal = size_ok & align_ok;
  end

  logic [AW-1:0] idx;
  logic [4:0]    lane_sh;
  logic [31:0]   word_rd, word_sh, load_c;
  logic [31:0]   wmask, wshift, wmerged;

  assign idx     = a_c[AW+1:2];
  assign lane_sh = {a_c[1:0], 3'b000};
  assign word_rd = mem[idx];
  assign word_sh = word_rd >> lane_sh;

  // Load extraction and sign/zero extension
  always_comb begin
    load_c = '0;
    case (f3_c)
      3'b000:  load_c = {{24{word_sh[7]}}, word_sh[7:0]};
      3'b001:  load_c = {{16{word_sh[15]}}, word_sh[15:0]};
      3'b010:  load_c = word_rd;
      3'b100:  load_c = {24'h0, word_sh[7:0]};
      3'b101:  load_c = {16'h0, word_sh[15:0]};
      default: load_c = '0;
    endcase
  end

  // Store lane merge: only the addressed lanes change
  always_comb begin
    wmask = 32'hFFFF_FFFF;
    case (f3_c[1:0])
      2'b00:   wmask = 32'h0000_00FF;
      2'b01:   wmask = 32'h0000_FFFF;
      default: wmask = 32'hFFFF_FFFF;
    endcase
    wmask   = wmask << lane_sh;
    wshift  = wd_c << lane_sh;
    wmerged = (word_rd & ~wmask) | (wshift & wmask);
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    accept    = 1'b0;
    do_access = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          accept = 1'b1;
          if (!legal) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else if (WAIT_CYCLES == 0) begin
            do_access = 1'b1;
            state_d   = RESP;
          end else begin
            cnt_d   = CW'(WAIT_CYCLES - 1);
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          do_access = 1'b1;
          state_d   = RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    rdata_d = (do_access && !st_c) ? load_c : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= (state_d == RESP);
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Request capture; a store is taken when both request lines are high
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      func3_q <= '0;
      store_q <= 1'b0;
    end else if (accept) begin
      addr_q  <= addr;
      wdata_q <= wdata;
      func3_q <= func3;
      store_q <= memwrite;
    end
  end

  // Array is deliberately not cleared by reset
  always_ff @(posedge clk) begin
    if (!rst && do_access && st_c) begin
      mem[idx] <= wmerged;
    end
  end

  assign busy  = ~rst & (((state_q == IDLE) & req) | (state_q == WAIT));
  assign done  = done_q;
  assign err   = err_q;
  assign rdata = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a WAIT_CYCLES=2 and a WAIT_CYCLES=0
// instance share stimulus, selected by sel.
module tb_dmem_responder;

  logic        clk;
  logic        rst;
  logic [31:0] addr, wdata;
  logic [2:0]  func3;
  logic        rd, wr, sel;

  logic [31:0] rdata2, rdata0;
  logic        busy2, busy0, done2, done0, err2, err0;

  logic [31:0] rdata_m;
  logic        busy_m, done_m, err_m;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [int];

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) u_dut2 (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata),
    .memread(rd & ~sel), .memwrite(wr & ~sel), .func3(func3),
    .rdata(rdata2), .busy(busy2), .done(done2), .err(err2)
  );

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata),
    .memread(rd & sel), .memwrite(wr & sel), .func3(func3),
    .rdata(rdata0), .busy(busy0), .done(done0), .err(err0)
  );

  assign rdata_m = sel ? rdata0 : rdata2;
  assign busy_m  = sel ? busy0  : busy2;
  assign done_m  = sel ? done0  : done2;
  assign err_m   = sel ? err0   : err2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference model: byte-lane walk over a word-indexed sparse memory
  function automatic exp_t model_access(input bit s, input bit r, input bit w,
                                        input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] wd);
    exp_t        e;
    int          key;
    int          nbytes;
    int          ln;
    logic [31:0] word, v;
    bit          bad;
    e.rdata = 32'h0;
    e.err   = 1'b0;
    key     = int'(s) * 1024 + int'(a[11:2]);
    if (w) bad = !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
    else   bad = !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    if (f3[1:0] == 2'd1 && a[0] != 1'b0)     bad = 1'b1;
    if (f3[1:0] == 2'd2 && a[1:0] != 2'd0)   bad = 1'b1;
    if (!r && !w) bad = 1'b1;
    if (bad) begin
      e.err = 1'b1;
      return e;
    end
    word   = model.exists(key) ? model[key] : 32'h0;
    nbytes = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    if (w) begin
      for (int b = 0; b < nbytes; b++) begin
        ln = int'(a[1:0]) + b;
        word[ln*8 +: 8] = wd[b*8 +: 8];
      end
      model[key] = word;
    end else begin
      v = 32'h0;
      for (int b = 0; b < nbytes; b++) begin
        ln = int'(a[1:0]) + b;
        v[b*8 +: 8] = word[ln*8 +: 8];
      end
      if (!f3[2] && nbytes == 1) v = {{24{v[7]}}, v[7:0]};
      if (!f3[2] && nbytes == 2) v = {{16{v[15]}}, v[15:0]};
      e.rdata = v;
    end
    return e;
  endfunction

  // Issue one request from IDLE; called and returns at a negedge
  task automatic do_req(input string tag, input bit s, input bit r, input bit w,
                        input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    int   nb;
    int   wc;
    bit   got;
    e  = model_access(s, r, w, f3, a, wd);
    sb.push_back(e);
    wc = s ? 0 : 2;
    sel = s; addr = a; wdata = wd; func3 = f3; rd = r; wr = w;
    #1;
    nb  = busy_m ? 1 : 0;
    got = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rd = 1'b0; wr = 1'b0;
    addr = $urandom; wdata = $urandom; func3 = 3'($urandom_range(7));
    for (int i = 0; i < 20 && !got; i++) begin
      if (done_m) begin
        got = 1'b1;
      end else begin
        if (busy_m) nb++;
        @(negedge clk);
      end
    end
    e = sb.pop_front();
    if (!got) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      check({tag, "_rdata"}, rdata_m, e.rdata);
      check({tag, "_err"}, 32'(err_m), 32'(e.err));
      check({tag, "_busy_cycles"}, 32'(nb), e.err ? 32'd1 : 32'(1 + wc));
      check({tag, "_busy_in_done"}, 32'(busy_m), 32'd0);
      @(negedge clk);
      check({tag, "_done_pulse"}, 32'({done_m, err_m}), 32'd0);
    end
  endtask

  // Store aborted by reset k cycles after acceptance (WAIT_CYCLES=2 instance)
  task automatic rst_mid(input string tag, input int k);
    bit saw;
    sel = 1'b0; addr = 32'h20; wdata = 32'h5A5A5A5A; func3 = 3'd2; wr = 1'b1; rd = 1'b0;
    @(posedge clk);
    @(negedge clk);
    wr = 1'b0;
    for (int i = 1; i < k; i++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check({tag, "_busy_in_rst"}, 32'(busy2), 32'd0);
    rst = 1'b0;
    saw = done2;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      saw = saw | done2;
    end
    check({tag, "_no_done"}, 32'(saw), 32'd0);
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0; rd = 1'b0; wr = 1'b0;
    addr = '0; wdata = '0; func3 = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'({busy2, busy0}), 32'd0);
    check("rst_done", 32'({done2, done0, err2, err0}), 32'd0);
    check("rst_rdata2", rdata2, 32'd0);
    check("rst_rdata0", rdata0, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    do_req("sw10",   0, 0, 1, 3'd2, 32'h10,  32'hDEADBEEF);
    do_req("lw10",   0, 1, 0, 3'd2, 32'h10,  32'h0);
    do_req("sw100",  0, 0, 1, 3'd2, 32'h100, 32'h11223344);
    do_req("sb103",  0, 0, 1, 3'd0, 32'h103, 32'h80);
    do_req("lw100",  0, 1, 0, 3'd2, 32'h100, 32'h0);
    do_req("lb103",  0, 1, 0, 3'd0, 32'h103, 32'h0);
    do_req("lbu103", 0, 1, 0, 3'd4, 32'h103, 32'h0);
    do_req("lh102",  0, 1, 0, 3'd1, 32'h102, 32'h0);
    do_req("lhu100", 0, 1, 0, 3'd5, 32'h100, 32'h0);
    do_req("sh101",  0, 0, 1, 3'd1, 32'h101, 32'hABCD);
    do_req("lw100b", 0, 1, 0, 3'd2, 32'h100, 32'h0);
    do_req("ld011",  0, 1, 0, 3'd3, 32'h100, 32'h0);
    do_req("st100",  0, 0, 1, 3'd4, 32'h100, 32'hFFFFFFFF);
    do_req("lw102",  0, 1, 0, 3'd2, 32'h102, 32'h0);
    do_req("lw100c", 0, 1, 0, 3'd2, 32'h100, 32'h0);

    do_req("sw20z",  0, 0, 1, 3'd2, 32'h20,  32'h0);
    rst_mid("rst_w1", 1);
    do_req("lw20a",  0, 1, 0, 3'd2, 32'h20,  32'h0);
    rst_mid("rst_acc", 2);
    do_req("lw20b",  0, 1, 0, 3'd2, 32'h20,  32'h0);

    do_req("sw1004", 0, 0, 1, 3'd2, 32'h1004, 32'hCAFEF00D);
    do_req("lw4",    0, 1, 0, 3'd2, 32'h4,    32'h0);

    do_req("w0_sw8",  1, 0, 1, 3'd2, 32'h8, 32'h12345678);
    do_req("w0_lw8a", 1, 1, 0, 3'd2, 32'h8, 32'h0);
    do_req("w0_lw8b", 1, 1, 0, 3'd2, 32'h8, 32'h0);
    do_req("w0_both", 1, 1, 1, 3'd2, 32'h0, 32'h7);
    do_req("w0_lw0",  1, 1, 0, 3'd2, 32'h0, 32'h0);
    do_req("w0_sh2",  1, 0, 1, 3'd1, 32'h2, 32'h9876);
    do_req("w0_lh2",  1, 1, 0, 3'd1, 32'h2, 32'h0);
    do_req("w0_lw1",  1, 1, 0, 3'd2, 32'h1, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder on the far end of the pipeline's MEM-stage load/store interface.
- Accepts memread/memwrite requests carrying address, store data and func3, and inserts a configurable number of wait states.
- Raises a combinational busy so the pipeline can freeze, then returns sign/zero-extended load data with a one-cycle done pulse.
- Flags misaligned or illegal-size accesses instead of performing them.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words; power of two.
- WAIT_CYCLES, 2, wait states between accept and access; 0 allowed.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; synchronous, active-high.
- addr  input  32  byte address.
- wdata  input  32  store data, right-justified.
- memread  input  1  load request.
- memwrite  input  1  store request.
- func3  input  3  access size/sign.
- rdata  output  32  load result; valid while done=1.
- busy  output  1  stall request to pipeline.
- done  output  1  one-cycle completion pulse.
- err  output  1  one-cycle error pulse, concurrent with done.

Behaviour:
- Reset (rst=1 at edge):
  - state=IDLE, wait counter=0, rdata=0, done=0, err=0.
  - busy is forced 0 while rst=1.
  - Memory array is not cleared.
- FSM states: IDLE, WAIT, RESP.
- req = memread | memwrite. If both are high, the request is a store; the read is ignored.
- IDLE:
  - If req, latch addr, wdata, func3 and op at the edge; this is the accept edge E0.
  - Misaligned or illegal request -> RESP with err pending.
  - Otherwise, if WAIT_CYCLES=0 -> perform access at E0, go to RESP.
  - Otherwise -> WAIT with counter = WAIT_CYCLES-1.
- WAIT:
  - Counter decrements each edge.
  - At the edge where counter=0, perform the access and go to RESP.
  - Access edge = E0+WAIT_CYCLES.
  - Input changes during WAIT are ignored.
- RESP:
  - done=1 for exactly one cycle; err=1 if error.
  - rdata = load result for loads, 0 for stores and errors.
  - Next edge -> IDLE.
  - Requests are never accepted in RESP; the requester must present its next request from IDLE.
- busy (combinational) = (state==IDLE & req) | (state==WAIT).
  - Low in RESP, so the pipeline advances in the done cycle.
  - A single request therefore stalls 1+WAIT_CYCLES cycles.
- Registered outputs: done, err, rdata.
- Addressing:
  - Word index = addr[log2(DEPTH_WORDS)+1:2]; upper bits ignored (wrap-around aliasing).
  - Byte lane = addr[1:0]; little-endian.
- func3 encoding:
  - Loads: 000 LB sign-ext, 001 LH sign-ext, 010 LW, 100 LBU zero-ext, 101 LHU zero-ext.
  - Stores: 000 SB, 001 SH, 010 SW; SB writes wdata[7:0] and SH writes wdata[15:0] into the addressed lanes only; other lanes unchanged.
  - Any other func3 for that op is illegal: err, no write.
- Alignment: halfword requires addr[0]=0; word requires addr[1:0]=00. Violation -> err, no write, rdata=0, latency 1 cycle (IDLE->RESP).
- Reset mid-operation: rst in WAIT or RESP returns to IDLE. A store whose access edge has not yet occurred is discarded; memory is unchanged. A reset coinciding with the access edge takes priority, so no write occurs.
- Write-then-read: a load issued after a store's done returns the new data.

Test Plan:
- WAIT_CYCLES=2: SW addr 0x10 wdata 0xDEADBEEF, then LW 0x10 -> busy high 3 cycles each, done one cycle later, rdata=0xDEADBEEF, err=0.
- SW 0x100 = 0x11223344; SB 0x103 wdata 0x80 -> LW 0x100=0x80223344, LB 0x103=0xFFFFFF80, LBU 0x103=0x00000080, LH 0x102=0xFFFF8022, LHU 0x100=0x00003344.
- SH addr 0x101 wdata 0xABCD -> err=1 with done, 1-cycle latency, busy 1 cycle. Subsequent LW 0x100 unchanged. func3=011 load -> err=1.
- Start SW 0x20=0x5A5A5A5A over prior value 0; assert rst for one cycle during WAIT -> done never pulses, busy=0, subsequent LW 0x20 returns 0.
- WAIT_CYCLES=0 build: back-to-back LW each complete with busy one cycle, done the next. With memread=memwrite=1, wdata=0x7 at 0x0 -> store performed, rdata=0.
- DEPTH_WORDS=1024: SW 0x1004=0xCAFEF00D -> LW 0x4 returns 0xCAFEF00D (wrap-around aliasing).
